// File: rtl/column_slice_drawer.sv
// -----------------------------------------------------------------------------
// column_slice_drawer
//
// Sweeps a frame column by column. For each column it asks an external
// slice-height calculator for the wall height, then plots one full column of
// pixels: ceiling above the wall, wall in the middle and floor below it.
// A column whose height never arrives is drawn with height 0 after TIMEOUT
// cycles, so the sweep always completes.
//
// Ports
//   clock        : single clock, rising edge
//   reset        : asynchronous, active-high
//   start_frame  : request one frame sweep (ignored while busy)
//   column_count : column index presented to the calculator
//   begin_calc   : one-cycle request to the calculator
//   end_calc     : calculator completion strobe (sampled only while waiting)
//   slice_size   : wall height, valid with end_calc
//   x, y         : pixel coordinates
//   colour       : pixel colour
//   plot         : pixel write enable, one pixel per asserted cycle
//   busy         : high whenever not idle
//   frame_done   : one-cycle pulse at the end of a completed frame
// -----------------------------------------------------------------------------
module column_slice_drawer #(
   parameter int         NUM_COLS  = 160,
   parameter int         SCREEN_H  = 120,
   parameter int         TIMEOUT   = 255,
   parameter logic [2:0] CEIL_COL  = 3'b001,
   parameter logic [2:0] WALL_COL  = 3'b100,
   parameter logic [2:0] FLOOR_COL = 3'b010
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start_frame,
   output logic [7:0] column_count,
   output logic       begin_calc,
   input  logic       end_calc,
   input  logic [6:0] slice_size,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAW, NEXT, DONE} state_t;

   localparam int            TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [6:0]    H_MAX    = 7'(SCREEN_H);
   localparam logic [6:0]    Y_LAST   = 7'(SCREEN_H - 1);
   localparam logic [7:0]    COL_LAST = 8'(NUM_COLS - 1);
   localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

   state_t        state;
   logic [6:0]    h;
   logic [6:0]    top;
   logic [TW-1:0] tcount;

   // Height and band edges for the column about to be drawn. A missing
   // end_calc (the timeout path) naturally yields h = 0.
   logic [6:0] h_next, top_next, bottom_next;
   logic [6:0] bottom;
   logic [6:0] y_inc;

   always_comb begin
      h_next = '0;
      if (end_calc)
         h_next = (slice_size > H_MAX) ? H_MAX : slice_size;
      top_next    = (H_MAX - h_next) >> 1;
      bottom_next = top_next + h_next;
      bottom      = top + h;
      y_inc       = y + 7'd1;
   end

   function automatic logic [2:0] pick(input logic [6:0] row,
                                       input logic [6:0] t,
                                       input logic [6:0] b);
      if (row < t)      return CEIL_COL;
      else if (row < b) return WALL_COL;
      else              return FLOOR_COL;
   endfunction

   // NOTE: state and outputs are registers, so every assignment here is
   // non-blocking; blocking assignments would make results order-dependent.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         column_count <= '0;
         x            <= '0;
         y            <= '0;
         colour       <= '0;
         h            <= '0;
         top          <= '0;
         tcount       <= '0;
         begin_calc   <= 1'b0;
         plot         <= 1'b0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_frame) begin
                  column_count <= '0;
                  x            <= '0;
                  begin_calc   <= 1'b1;
                  busy         <= 1'b1;
                  state        <= REQ;
               end
            end

            REQ: begin
               begin_calc <= 1'b0;
               tcount     <= '0;
               state      <= WAIT;
            end

            WAIT: begin
               // Either a real height or the timeout: both start drawing,
               // and the first pixel (y = 0) is set up on the way in.
               if (end_calc || tcount == T_LAST) begin
                  h      <= h_next;
                  top    <= top_next;
                  y      <= '0;
                  colour <= pick(7'd0, top_next, bottom_next);
                  plot   <= 1'b1;
                  state  <= DRAW;
               end else begin
                  tcount <= tcount + 1'b1;
               end
            end

            DRAW: begin
               if (y == Y_LAST) begin
                  plot  <= 1'b0;
                  state <= NEXT;
               end else begin
                  y      <= y_inc;
                  colour <= pick(y_inc, top, bottom);
               end
            end

            NEXT: begin
               if (column_count == COL_LAST) begin
                  frame_done <= 1'b1;
                  state      <= DONE;
               end else begin
                  column_count <= column_count + 8'd1;
                  x            <= column_count + 8'd1;
                  begin_calc   <= 1'b1;
                  state        <= REQ;
               end
            end

            DONE: begin
               frame_done <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_column_slice_drawer.sv
// -----------------------------------------------------------------------------
// tb_column_slice_drawer
//
// Directed bench for column_slice_drawer at default parameters. A behavioural
// calculator answers each begin_calc three cycles later with a programmable
// height; it can also skip one column or inject a stray end_calc mid-draw.
// A monitor records every plotted pixel and every request so the scenario
// tasks can compare the result against hand-derived column patterns.
// -----------------------------------------------------------------------------
module tb_column_slice_drawer;

   localparam int         NUM_COLS  = 160;
   localparam int         SCREEN_H  = 120;
   localparam logic [2:0] CEIL_COL  = 3'b001;
   localparam logic [2:0] WALL_COL  = 3'b100;
   localparam logic [2:0] FLOOR_COL = 3'b010;

   logic       clock = 1'b0;
   logic       reset;
   logic       start_frame;
   logic [7:0] column_count;
   logic       begin_calc;
   logic       end_calc = 1'b0;
   logic [6:0] slice_size = '0;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       frame_done;

   int n_cmp = 0;
   int n_bad = 0;

   // calculator configuration
   logic [6:0] slice_val = 7'd40;
   int         skip_col  = -1;
   logic       spurious  = 1'b0;

   // monitor records
   logic [2:0] px [0:NUM_COLS-1][0:SCREEN_H-1];
   int         pix_cnt [0:NUM_COLS-1];
   int         bt [0:NUM_COLS-1];
   int         begin_cnt, fd_cnt, seq_err, xbad;
   int         cyc = 0;

   column_slice_drawer dut (
      .clock        (clock),
      .reset        (reset),
      .start_frame  (start_frame),
      .column_count (column_count),
      .begin_calc   (begin_calc),
      .end_calc     (end_calc),
      .slice_size   (slice_size),
      .x            (x),
      .y            (y),
      .colour       (colour),
      .plot         (plot),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   // Calculator model: sole driver of end_calc / slice_size.
   initial begin
      int pend;
      pend = 0;
      forever begin
         @(negedge clock);
         end_calc   = 1'b0;
         slice_size = '0;
         if (reset) begin
            pend = 0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  end_calc   = 1'b1;
                  slice_size = slice_val;
               end
            end else if (begin_calc && int'(column_count) != skip_col) begin
               pend = 3;
            end
            if (spurious && plot && y == 7'd50) begin
               end_calc   = 1'b1;
               slice_size = 7'd127;
            end
         end
      end
   end

   // Monitor
   always @(negedge clock) begin
      if (!reset) begin
         if (plot) begin
            if (x < NUM_COLS) begin
               px[x][y] = colour;
               pix_cnt[x]++;
            end
            if (x !== column_count) xbad++;
         end
         if (begin_calc) begin
            if (int'(column_count) != begin_cnt) seq_err++;
            if (column_count < NUM_COLS) bt[column_count] = cyc;
            begin_cnt++;
         end
         if (frame_done) fd_cnt++;
      end
   end

   task automatic clear_stats();
      for (int c = 0; c < NUM_COLS; c++) begin
         pix_cnt[c] = 0;
         bt[c]      = 0;
         for (int r = 0; r < SCREEN_H; r++) px[c][r] = 3'b111;
      end
      begin_cnt = 0;
      fd_cnt    = 0;
      seq_err   = 0;
      xbad      = 0;
   endtask

   function automatic int col_errs(input int c, input int t, input int b);
      int e;
      logic [2:0] ex;
      e = 0;
      for (int r = 0; r < SCREEN_H; r++) begin
         ex = (r < t) ? CEIL_COL : ((r < b) ? WALL_COL : FLOOR_COL);
         if (px[c][r] !== ex) e++;
      end
      return e;
   endfunction

   task automatic pulse_start();
      @(negedge clock) start_frame = 1'b1;
      @(negedge clock) start_frame = 1'b0;
   endtask

   task automatic abort_frame();
      @(negedge clock) reset = 1'b1;
      @(negedge clock) reset = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic wait_begins(input int n, input int budget, input string what);
      int k;
      k = 0;
      while (begin_cnt < n && k < budget) begin
         @(negedge clock);
         k++;
      end
      if (begin_cnt < n) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: timed out with %0d requests, required %0d", what, begin_cnt, n);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      repeat (2) @(negedge clock);
      n_cmp++;
      if ({column_count, x, y, colour} !== 26'd0) begin
         n_bad++;
         $display("FAIL reset_data: got cc=%0d x=%0d y=%0d col=%0d, required all 0",
                  column_count, x, y, colour);
      end
      n_cmp++;
      if ({begin_calc, plot, busy, frame_done} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b, required 0000", {begin_calc, plot, busy, frame_done});
      end
      reset = 1'b0;
      repeat (5) @(negedge clock);
      n_cmp++;
      if (busy !== 1'b0 || begin_cnt !== 0) begin
         n_bad++;
         $display("FAIL idle_after_reset: busy=%b requests=%0d, required 0/0", busy, begin_cnt);
      end
   endtask

   task automatic test_full_frame();
      int k, bad_cols, errs;
      clear_stats();
      slice_val = 7'd40;
      pulse_start();
      n_cmp++;
      if ({begin_calc, busy, column_count} !== {2'b11, 8'd0}) begin
         n_bad++;
         $display("FAIL first_req: begin_calc=%b busy=%b cc=%0d, required 1 1 0",
                  begin_calc, busy, column_count);
      end
      k = 0;
      while (fd_cnt == 0 && k < 25000) begin
         @(negedge clock);
         k++;
      end
      repeat (3) @(negedge clock);
      n_cmp++;
      if (fd_cnt !== 1) begin
         n_bad++;
         $display("FAIL frame_done_count: got %0d, required 1", fd_cnt);
      end
      n_cmp++;
      if (begin_cnt !== 160 || seq_err !== 0) begin
         n_bad++;
         $display("FAIL requests: got %0d (seq errors %0d), required 160 (0)", begin_cnt, seq_err);
      end
      n_cmp++;
      if (column_count !== 8'd159 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL end_state: cc=%0d busy=%b, required 159 0", column_count, busy);
      end
      bad_cols = 0;
      errs     = 0;
      for (int c = 0; c < NUM_COLS; c++) begin
         if (pix_cnt[c] != SCREEN_H) bad_cols++;
         errs += col_errs(c, 40, 80);
      end
      n_cmp++;
      if (bad_cols !== 0 || xbad !== 0) begin
         n_bad++;
         $display("FAIL pixel_counts: %0d columns off, %0d x errors, required 0 0", bad_cols, xbad);
      end
      n_cmp++;
      if (errs !== 0) begin
         n_bad++;
         $display("FAIL frame_colours: %0d wrong pixels, required 0", errs);
      end
      n_cmp++;
      if (bt[1] - bt[0] !== 125 || bt[159] - bt[158] !== 125) begin
         n_bad++;
         $display("FAIL column_latency: got %0d/%0d cycles, required 125",
                  bt[1] - bt[0], bt[159] - bt[158]);
      end
   endtask

   task automatic test_clamp();
      clear_stats();
      slice_val = 7'd127;
      pulse_start();
      wait_begins(3, 400, "clamp_wait");
      abort_frame();
      n_cmp++;
      if (pix_cnt[0] !== 120 || pix_cnt[1] !== 120) begin
         n_bad++;
         $display("FAIL clamp_count: got %0d/%0d, required 120", pix_cnt[0], pix_cnt[1]);
      end
      n_cmp++;
      if (col_errs(0, 0, 120) !== 0 || col_errs(1, 0, 120) !== 0) begin
         n_bad++;
         $display("FAIL clamp_all_wall: %0d/%0d wrong pixels, required 0",
                  col_errs(0, 0, 120), col_errs(1, 0, 120));
      end
      n_cmp++;
      if (fd_cnt !== 0) begin
         n_bad++;
         $display("FAIL clamp_abort: frame_done count %0d, required 0", fd_cnt);
      end
   endtask

   task automatic test_odd_height();
      clear_stats();
      slice_val = 7'd41;
      pulse_start();
      wait_begins(2, 300, "odd_wait");
      abort_frame();
      n_cmp++;
      if ({px[0][38], px[0][39], px[0][79], px[0][80]} !== {CEIL_COL, WALL_COL, WALL_COL, FLOOR_COL}) begin
         n_bad++;
         $display("FAIL odd_edges: y38=%0d y39=%0d y79=%0d y80=%0d, required 1 4 4 2",
                  px[0][38], px[0][39], px[0][79], px[0][80]);
      end
      n_cmp++;
      if (col_errs(0, 39, 80) !== 0) begin
         n_bad++;
         $display("FAIL odd_column: %0d wrong pixels, required 0", col_errs(0, 39, 80));
      end
   endtask

   task automatic test_timeout();
      clear_stats();
      slice_val = 7'd40;
      skip_col  = 5;
      pulse_start();
      wait_begins(8, 2000, "timeout_wait");
      abort_frame();
      skip_col = -1;
      n_cmp++;
      if (pix_cnt[5] !== 120 || col_errs(5, 60, 60) !== 0) begin
         n_bad++;
         $display("FAIL timeout_column: count %0d, %0d wrong pixels, required 120 0",
                  pix_cnt[5], col_errs(5, 60, 60));
      end
      n_cmp++;
      if (bt[6] - bt[5] !== 377 || bt[5] - bt[4] !== 125) begin
         n_bad++;
         $display("FAIL timeout_latency: got %0d/%0d, required 377/125",
                  bt[6] - bt[5], bt[5] - bt[4]);
      end
      n_cmp++;
      if (seq_err !== 0 || col_errs(6, 40, 80) !== 0) begin
         n_bad++;
         $display("FAIL timeout_continue: seq errors %0d, col6 wrong %0d, required 0 0",
                  seq_err, col_errs(6, 40, 80));
      end
   endtask

   task automatic test_spurious();
      int bad;
      clear_stats();
      slice_val = 7'd40;
      spurious  = 1'b1;
      pulse_start();
      wait_begins(3, 400, "spurious_wait");
      @(negedge clock) start_frame = 1'b1;
      @(negedge clock) start_frame = 1'b0;
      wait_begins(5, 600, "spurious_wait2");
      abort_frame();
      spurious = 1'b0;
      bad = 0;
      for (int c = 0; c < 4; c++)
         if (pix_cnt[c] != 120 || col_errs(c, 40, 80) != 0) bad++;
      n_cmp++;
      if (bad !== 0) begin
         n_bad++;
         $display("FAIL spurious_columns: %0d bad columns, required 0", bad);
      end
      n_cmp++;
      if (seq_err !== 0 || fd_cnt !== 0) begin
         n_bad++;
         $display("FAIL spurious_sequence: seq errors %0d frame_done %0d, required 0 0",
                  seq_err, fd_cnt);
      end
   endtask

   task automatic test_reset_mid();
      clear_stats();
      slice_val = 7'd40;
      pulse_start();
      wait_begins(11, 1600, "mid_wait");
      repeat (60) @(negedge clock);
      n_cmp++;
      if (plot !== 1'b1 || column_count !== 8'd10) begin
         n_bad++;
         $display("FAIL mid_drawing: plot=%b cc=%0d, required 1 10", plot, column_count);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({plot, busy, begin_calc} !== 3'b000 || column_count !== 8'd0) begin
         n_bad++;
         $display("FAIL mid_reset_async: plot/busy/req=%b cc=%0d, required 000 0",
                  {plot, busy, begin_calc}, column_count);
      end
      @(negedge clock) reset = 1'b0;
      repeat (20) @(negedge clock);
      n_cmp++;
      if (busy !== 1'b0 || fd_cnt !== 0 || begin_cnt !== 11) begin
         n_bad++;
         $display("FAIL mid_idle: busy=%b frame_done=%0d requests=%0d, required 0 0 11",
                  busy, fd_cnt, begin_cnt);
      end
      clear_stats();
      pulse_start();
      n_cmp++;
      if (begin_calc !== 1'b1 || column_count !== 8'd0) begin
         n_bad++;
         $display("FAIL restart: begin_calc=%b cc=%0d, required 1 0", begin_calc, column_count);
      end
      wait_begins(2, 300, "restart_wait");
      abort_frame();
      n_cmp++;
      if (seq_err !== 0 || col_errs(0, 40, 80) !== 0) begin
         n_bad++;
         $display("FAIL restart_column: seq errors %0d wrong pixels %0d, required 0 0",
                  seq_err, col_errs(0, 40, 80));
      end
   endtask

   initial begin
      reset       = 1'b1;
      start_frame = 1'b0;
      clear_stats();
      test_reset();
      test_full_frame();
      test_clamp();
      test_odd_height();
      test_timeout();
      test_spurious();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/column_slice_drawer.md
COLUMN_SLICE_DRAWER -- requirements
Module: column_slice_drawer

Interface
REQ-001 SHALL have parameter NUM_COLS, default 160: columns per frame, swept 0..NUM_COLS-1.
REQ-002 SHALL have parameter SCREEN_H, default 120: pixel rows per column, at most 127.
REQ-003 SHALL have parameter TIMEOUT, default 255: cycles to wait for end_calc before forcing height 0.
REQ-004 SHALL have parameters CEIL_COL, default 3'b001; WALL_COL, default 3'b100; FLOOR_COL, default 3'b010: 3-bit pixel colours.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start_frame, input, 1 bit: request one full frame sweep.
REQ-008 SHALL have port column_count, output, 8 bits: column index presented to the slice-height calculator.
REQ-009 SHALL have port begin_calc, output, 1 bit: one-cycle request to the slice-height calculator.
REQ-010 SHALL have port end_calc, input, 1 bit: calculator completion strobe.
REQ-011 SHALL have port slice_size, input, 7 bits: unsigned wall height, valid while end_calc=1.
REQ-012 SHALL have port x, output, 8 bits: pixel column, equal to column_count.
REQ-013 SHALL have port y, output, 7 bits: pixel row.
REQ-014 SHALL have port colour, output, 3 bits: pixel colour.
REQ-015 SHALL have port plot, output, 1 bit: pixel write enable, one pixel per asserted cycle.
REQ-016 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-017 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-018 SHALL use the states IDLE, REQ, WAIT, DRAW, NEXT and DONE; all outputs are registered.
REQ-019 IDLE SHALL go to REQ on start_frame=1, clearing column_count to 0.
REQ-020 REQ SHALL last exactly one cycle with begin_calc=1, clear the timeout counter, then go to WAIT.
REQ-021 WAIT SHALL sample end_calc only in this state; on end_calc=1, latch h=min(slice_size,SCREEN_H), clear y, go to DRAW.
REQ-022 If end_calc stays low for TIMEOUT cycles in WAIT, the block SHALL latch h=0 and go to DRAW; end_calc arriving in REQ, DRAW, NEXT or IDLE SHALL be ignored.
REQ-023 On entering DRAW, top SHALL be computed as (SCREEN_H-h)>>1 (floor) and bottom as top+h.
REQ-024 DRAW SHALL assert plot every cycle for y=0..SCREEN_H-1 (SCREEN_H cycles), with x=column_count.
REQ-025 Colour in DRAW SHALL be CEIL_COL for y<top, WALL_COL for top<=y<bottom, and FLOOR_COL for y>=bottom.
REQ-026 After the y=SCREEN_H-1 pixel, the block SHALL go to NEXT.
REQ-027 NEXT SHALL go to DONE if column_count=NUM_COLS-1; otherwise it SHALL increment column_count and go to REQ.
REQ-028 DONE SHALL pulse frame_done=1 for one cycle, then go to IDLE; column_count SHALL hold NUM_COLS-1.
REQ-029 start_frame while busy=1 SHALL be ignored, with no queuing.
REQ-030 With h=0 the column SHALL be ceiling then floor (top=bottom=SCREEN_H/2); with h=SCREEN_H the whole column SHALL be WALL_COL.
REQ-031 Per-column latency SHALL be 1 (REQ) + wait + SCREEN_H (DRAW) + 1 (NEXT) cycles.

Reset
REQ-032 While reset=1, asynchronously: state=IDLE; column_count, x, y, colour, h and timeout counter = 0; begin_calc, plot, busy, frame_done = 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no frame_done; after release the block SHALL idle until a new start_frame.

Verification
REQ-034 Defaults; start_frame pulse; calculator model returns end_calc 3 cycles after each begin_calc with slice_size=40 -> 160 begin_calc pulses, column_count 0..159; each column: y0-39 CEIL, y40-79 WALL, y80-119 FLOOR; one frame_done.
REQ-035 slice_size=127 (>SCREEN_H) -> h clamped to 120; all 120 pixels WALL_COL.
REQ-036 slice_size=41 -> top=39, bottom=80; y39 WALL, y80 FLOOR.
REQ-037 end_calc never asserted for column 5 -> after 255 WAIT cycles column 5 drawn as 60 CEIL + 60 FLOOR; sweep continues at column 6.
REQ-038 Spurious end_calc during DRAW and start_frame during WAIT -> no effect; pixel count per column exactly 120.
REQ-039 reset pulse during column 10 DRAW -> plot, busy, begin_calc 0 immediately; no frame_done; next start_frame restarts at column 0.
